// File: rtl/alu_sequencer.sv
// alu_sequencer: 4-cycle IDLE/DECODE/EXEC/WB execute controller for the 16-bit ALU datapath.
// Optional macro SEQ_BCOND_EN adds conditional-branch support (op 1100) and its two outputs.
module alu_sequencer #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [15:0]       instr,
    output logic [REG_AW-1:0] rf_ra,
    output logic [REG_AW-1:0] rf_rb,
    input  logic [DATA_W-1:0] rf_a,
    input  logic [DATA_W-1:0] rf_b,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [7:0]        alu_op,
    input  logic [DATA_W-1:0] alu_c,
    input  logic [4:0]        alu_flags,
    output logic              wb_en,
    output logic [REG_AW-1:0] wb_addr,
    output logic [DATA_W-1:0] wb_data,
    output logic [4:0]        psr,
    output logic              done,
    output logic              illegal
`ifdef SEQ_BCOND_EN
    ,
    output logic              branch_taken,
    output logic [15:0]       branch_disp
`endif
);

    typedef enum logic [1:0] {IDLE, DECODE, EXEC, WB} state_t;

    state_t             state_reg, state_next;
    logic [15:0]        ir_reg;
    logic [DATA_W-1:0]  res_reg;
    logic [4:0]         fl_reg;
    logic [4:0]         psr_reg;

    logic [3:0]         op, ext;
    logic               rtype;
    logic               cls_legal, cls_wb;
    logic [4:0]         cls_mask;

    assign op    = ir_reg[15:12];
    assign ext   = ir_reg[7:4];
    assign rf_ra = ir_reg[11:8];
    assign rf_rb = ir_reg[3:0];
    assign psr   = psr_reg;
    assign rtype = (op == 4'b0000) || ((op == 4'b1000) && ((ext == 4'b0100) || (ext == 4'b0110)));

    // Register and immediate forms share one code space: {legal, writes_back, mask}
    function automatic logic [6:0] arith_class(input logic [3:0] code);
        case (code)
            4'b0101:                   arith_class = {2'b11, 5'b10100};
            4'b1001:                   arith_class = {2'b11, 5'b11111};
            4'b1011:                   arith_class = {2'b10, 5'b01011};
            4'b0001:                   arith_class = {2'b11, 5'b00010};
            4'b0110, 4'b0010, 4'b0011,
            4'b1101:                   arith_class = {2'b11, 5'b00000};
            default:                   arith_class = 7'b0;
        endcase
    endfunction

`ifdef SEQ_BCOND_EN
    logic is_bcond;
`endif

    always_comb begin
        {cls_legal, cls_wb, cls_mask} = 7'b0;
`ifdef SEQ_BCOND_EN
        is_bcond = 1'b0;
`endif
        case (op)
            4'b0000: {cls_legal, cls_wb, cls_mask} = arith_class(ext);
            4'b1000: begin
                if (ext == 4'b0100 || ext == 4'b0110 || ext[3:2] == 2'b00)
                    {cls_legal, cls_wb, cls_mask} = {2'b11, 5'b00000};
            end
            4'b1111: {cls_legal, cls_wb, cls_mask} = {2'b11, 5'b00000};
`ifdef SEQ_BCOND_EN
            4'b1100: begin
                {cls_legal, cls_wb, cls_mask} = {2'b10, 5'b00000};
                is_bcond = 1'b1;
            end
`endif
            default: {cls_legal, cls_wb, cls_mask} = arith_class(op);
        endcase
    end

    always_comb begin
        state_next  = state_reg;
        instr_ready = 1'b0;
        done        = 1'b0;
        illegal     = 1'b0;
        wb_en       = 1'b0;
        wb_addr     = '0;
        wb_data     = '0;
        case (state_reg)
            IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) state_next = DECODE;
            end
            DECODE: state_next = EXEC;
            EXEC:   state_next = WB;
            WB: begin
                state_next = IDLE;
                done       = 1'b1;
                illegal    = ~cls_legal;
                if (cls_legal && cls_wb) begin
                    wb_en   = 1'b1;
                    wb_addr = ir_reg[11:8];
                    wb_data = res_reg;
                end
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef SEQ_BCOND_EN
    logic cond_true;
    always_comb begin
        cond_true = 1'b0;
        case (ir_reg[11:8])   // psr bits: C=4 L=3 F=2 Z=1 N=0
            4'b0000: cond_true = psr_reg[1];
            4'b0001: cond_true = ~psr_reg[1];
            4'b0010: cond_true = psr_reg[4];
            4'b0011: cond_true = ~psr_reg[4];
            4'b0100: cond_true = psr_reg[3];
            4'b0101: cond_true = ~psr_reg[3];
            4'b0110: cond_true = psr_reg[0];
            4'b0111: cond_true = ~psr_reg[0];
            4'b1000: cond_true = psr_reg[2];
            4'b1001: cond_true = ~psr_reg[2];
            4'b1010: cond_true = ~psr_reg[3] & ~psr_reg[1];
            4'b1011: cond_true = psr_reg[3] | psr_reg[1];
            4'b1100: cond_true = ~psr_reg[0] & ~psr_reg[1];
            4'b1101: cond_true = psr_reg[0] | psr_reg[1];
            4'b1110: cond_true = 1'b1;
            default: cond_true = 1'b0;
        endcase
        branch_taken = (state_reg == WB) && is_bcond && cond_true;
        branch_disp  = ((state_reg == WB) && is_bcond) ? {{8{ir_reg[7]}}, ir_reg[7:0]} : 16'h0000;
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            ir_reg    <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= '0;
            res_reg   <= '0;
            fl_reg    <= '0;
            psr_reg   <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: if (instr_valid) ir_reg <= instr;
                DECODE: begin
                    alu_a  <= rf_a;
                    alu_b  <= rtype ? rf_b : {{(DATA_W-8){1'b0}}, ir_reg[7:0]};
                    alu_op <= {op, ext};
                end
                EXEC: begin
                    res_reg <= alu_c;
                    fl_reg  <= alu_flags;
                end
                WB: psr_reg <= (psr_reg & ~cls_mask) | (fl_reg & cls_mask);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: behavioural register file and ALU, hand-computed expectations.
// Build with SEQ_BCOND_EN defined to also exercise the conditional-branch vectors.
module tb_alu_sequencer;

    logic        clk;
    logic        reset_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [3:0]  rf_ra, rf_rb;
    logic [15:0] rf_a, rf_b;
    logic [15:0] alu_a, alu_b;
    logic [7:0]  alu_op;
    logic [15:0] alu_c;
    logic [4:0]  alu_flags;
    logic        wb_en;
    logic [3:0]  wb_addr;
    logic [15:0] wb_data;
    logic [4:0]  psr;
    logic        done;
    logic        illegal;
`ifdef SEQ_BCOND_EN
    logic        branch_taken;
    logic [15:0] branch_disp;
`endif

    alu_sequencer dut (
        .clk(clk), .reset_n(reset_n),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .rf_ra(rf_ra), .rf_rb(rf_rb), .rf_a(rf_a), .rf_b(rf_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_c(alu_c), .alu_flags(alu_flags),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .psr(psr), .done(done), .illegal(illegal)
`ifdef SEQ_BCOND_EN
        , .branch_taken(branch_taken), .branch_disp(branch_disp)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file: combinational reads, write on the strobe
    logic [15:0] rf [16];
    assign rf_a = rf[rf_ra];
    assign rf_b = rf[rf_rb];
    always @(posedge clk) if (wb_en) rf[wb_addr] <= wb_data;

    // Minimal ALU; flag bits that the class must not touch are deliberately set to 1
    logic [3:0]  alu_key;
    logic [16:0] alu_sum;
    always_comb begin
        alu_key   = (alu_op[7:4] == 4'h0) ? alu_op[3:0] : alu_op[7:4];
        alu_sum   = {1'b0, alu_a} + {1'b0, alu_b};
        alu_c     = alu_a ^ alu_b;
        alu_flags = 5'b11111;
        case (alu_key)
            4'h5: begin
                alu_c     = alu_sum[15:0];
                alu_flags = {alu_sum[16], 1'b1,
                             (alu_a[15] == alu_b[15]) && (alu_sum[15] != alu_a[15]),
                             alu_sum[15:0] == 16'h0, 1'b1};
            end
            4'hB: begin
                alu_c     = alu_a - alu_b;
                alu_flags = {1'b1, alu_a < alu_b, 1'b0, alu_a == alu_b,
                             $signed(alu_a) < $signed(alu_b)};
            end
            4'h9: begin
                alu_c     = alu_a - alu_b;
                alu_flags = {4'b0000, 1'b0};
            end
            4'h1: begin
                alu_c     = alu_a & alu_b;
                alu_flags = {3'b111, (alu_a & alu_b) == 16'h0, 1'b1};
            end
            4'h2: begin
                alu_c     = alu_a | alu_b;
                alu_flags = {3'b111, (alu_a | alu_b) == 16'h0, 1'b1};
            end
            default: ;
        endcase
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    int          obs_done_at;
    int          obs_wb_cnt;
    logic [3:0]  obs_wb_addr;
    logic [15:0] obs_wb_data;
    logic        obs_illegal;
    logic        obs_bt;
    logic [15:0] obs_bd;

    // Issue one instruction from an IDLE negedge; returns at the negedge after WB
    task automatic run_instr(input logic [15:0] word);
        int waited;
        waited = 0;
        while (!instr_ready && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        check_eq("ready_before_issue", {31'b0, instr_ready}, 32'd1);
        instr       = word;
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        instr       = 16'h0000;
        obs_done_at = 0;
        obs_wb_cnt  = 0;
        obs_wb_addr = '0;
        obs_wb_data = '0;
        obs_illegal = 1'b0;
        obs_bt      = 1'b0;
        obs_bd      = '0;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (wb_en) begin
                obs_wb_cnt++;
                obs_wb_addr = wb_addr;
                obs_wb_data = wb_data;
            end
            if (done) begin
                obs_done_at = n;
                obs_illegal = illegal;
`ifdef SEQ_BCOND_EN
                obs_bt = branch_taken;
                obs_bd = branch_disp;
`endif
                break;
            end
        end
        @(negedge clk);
        $display("instr %h: done_at=%0d wb_cnt=%0d wb_addr=%0d wb_data=%h illegal=%0d psr=%b",
                 word, obs_done_at, obs_wb_cnt, obs_wb_addr, obs_wb_data, obs_illegal, psr);
        check_eq("done_latency", obs_done_at, 32'd3);
    endtask

    initial begin
        int wb_seen;
        reset_n     = 1'b0;
        instr_valid = 1'b0;
        instr       = 16'h0000;
        for (int i = 0; i < 16; i++) rf[i] = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_ready", {31'b0, instr_ready}, 32'd1);
        check_eq("rst_psr",   {27'b0, psr}, 32'd0);
        check_eq("rst_done",  {31'b0, done}, 32'd0);
        check_eq("rst_wb_en", {31'b0, wb_en}, 32'd0);
        check_eq("rst_alu_op", {24'b0, alu_op}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // ADD R1,R2: 0x7FFF + 1 overflows into 0x8000, only C and F recorded
        rf[1] = 16'h7FFF;
        rf[2] = 16'h0001;
        run_instr(16'h0152);
        check_eq("add_wb_cnt",  obs_wb_cnt, 32'd1);
        check_eq("add_wb_addr", {28'b0, obs_wb_addr}, 32'd1);
        check_eq("add_wb_data", {16'b0, obs_wb_data}, 32'h8000);
        check_eq("add_illegal", {31'b0, obs_illegal}, 32'd0);
        check_eq("add_psr",     {27'b0, psr}, 32'b00100);
        check_eq("add_rf1",     {16'b0, rf[1]}, 32'h8000);

        // CMP R3,R4: 5 vs 7 -> L=1 N=1 Z=0; C,F keep 0,1
        rf[3] = 16'h0005;
        rf[4] = 16'h0007;
        run_instr(16'h03B4);
        check_eq("cmp_wb_cnt", obs_wb_cnt, 32'd0);
        check_eq("cmp_psr",    {27'b0, psr}, 32'b01101);

        // ANDI R5,#0x0F on 0x00F0 -> 0, Z set
        rf[5] = 16'h00F0;
        run_instr(16'h150F);
        check_eq("andi_wb_data", {16'b0, obs_wb_data}, 32'h0000);
        check_eq("andi_wb_cnt",  obs_wb_cnt, 32'd1);
        check_eq("andi_psr",     {27'b0, psr}, 32'b01111);

        // ORI R5,#0x01 -> 1, PSR untouched
        run_instr(16'h2501);
        check_eq("ori_wb_data", {16'b0, obs_wb_data}, 32'h0001);
        check_eq("ori_psr",     {27'b0, psr}, 32'b01111);

        // ADDC is unsupported
        run_instr(16'h0172);
        check_eq("addc_illegal", {31'b0, obs_illegal}, 32'd1);
        check_eq("addc_wb_cnt",  obs_wb_cnt, 32'd0);
        check_eq("addc_psr",     {27'b0, psr}, 32'b01111);
        check_eq("addc_ready_after", {31'b0, instr_ready}, 32'd1);

        // SUB R1,R2 aborted by reset during EXEC
        rf[1] = 16'hFFFF;
        rf[2] = 16'h0001;
        instr       = 16'h0192;
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        instr       = 16'h0000;
        @(negedge clk);
        @(negedge clk);
        check_eq("sub_exec_alu_a", {16'b0, alu_a}, 32'h0000FFFF);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("abort_alu_a",  {16'b0, alu_a}, 32'd0);
        check_eq("abort_alu_b",  {16'b0, alu_b}, 32'd0);
        check_eq("abort_alu_op", {24'b0, alu_op}, 32'd0);
        check_eq("abort_psr",    {27'b0, psr}, 32'd0);
        check_eq("abort_done",   {31'b0, done}, 32'd0);
        wb_seen = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (wb_en || done) wb_seen++;
        end
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (wb_en || done) wb_seen++;
        end
        check_eq("abort_no_wb", wb_seen, 32'd0);
        check_eq("abort_rf1",   {16'b0, rf[1]}, 32'h0000FFFF);
        check_eq("abort_ready", {31'b0, instr_ready}, 32'd1);

        // ADD after reset: 0xFFFF + 1 -> 0 with carry out
        run_instr(16'h0152);
        check_eq("add2_wb_data", {16'b0, obs_wb_data}, 32'h0000);
        check_eq("add2_wb_cnt",  obs_wb_cnt, 32'd1);
        check_eq("add2_psr",     {27'b0, psr}, 32'b10000);

`ifdef SEQ_BCOND_EN
        // CMP R6,R6 sets Z, then BEQ -2 is taken
        rf[6] = 16'h1234;
        run_instr(16'h06B6);
        check_eq("cmpeq_psr", {27'b0, psr}, 32'b10010);
        run_instr(16'hC0FE);
        check_eq("beq_taken",  {31'b0, obs_bt}, 32'd1);
        check_eq("beq_disp",   {16'b0, obs_bd}, 32'h0000FFFE);
        check_eq("beq_wb_cnt", obs_wb_cnt, 32'd0);
        check_eq("beq_psr",    {27'b0, psr}, 32'b10010);
        // CMP R3,R4 clears Z, BEQ not taken
        run_instr(16'h03B4);
        run_instr(16'hC0FE);
        check_eq("bne_taken", {31'b0, obs_bt}, 32'd0);
        check_eq("br_idle_disp", {16'b0, branch_disp}, 32'd0);
`else
        // Without the branch option 1100 is unsupported
        run_instr(16'hC0FE);
        check_eq("bcond_off_illegal", {31'b0, obs_illegal}, 32'd1);
        check_eq("bcond_off_psr",     {27'b0, psr}, 32'b10000);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
